// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the PPU sprite DMA
package ppu_pkg;

    localparam logic [15:0] OAM_DMA_REG     = 16'h4014;
    localparam int          DMA_LEN_DEFAULT = 256;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - $4014 sprite DMA: halts the CPU and copies one page into OAM
module oam_dma
    import ppu_pkg::*;
#(
    parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic        reg_wr,
    input  logic [7:0]  reg_din,
    input  logic        stall,
    input  logic [7:0]  bus_din,
    output logic        cpu_halt,
    output logic        bus_rd,
    output logic [15:0] bus_addr,
    output logic [7:0]  oam_data_o,
    output logic        oam_data_wr
);

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

    dma_state_e  state_q, state_d;
    logic        put_q, put_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  oam_data_q, oam_data_d;
    logic        oam_wr_q, oam_wr_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        bus_rd_q, bus_rd_d;
    logic [15:0] bus_addr_q, bus_addr_d;

    always_comb begin
        state_d    = state_q;
        put_d      = put_q ^ cpu_ce;
        page_d     = page_q;
        index_d    = index_q;
        oam_data_d = oam_data_q;
        oam_wr_d   = 1'b0;

        case (state_q)
            DMA_IDLE: begin
                // Entry does not wait for cpu_ce; the HALT cycle is the next CPU cycle.
                if (reg_wr) begin
                    page_d  = reg_din;
                    index_d = 8'h00;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT: begin
                if (cpu_ce) begin
                    state_d = put_q ? DMA_READ : DMA_ALIGN;
                end
            end
            DMA_ALIGN: begin
                if (cpu_ce && put_q) begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                if (cpu_ce) begin
                    if (stall) begin
                        state_d = DMA_ALIGN;
                    end else begin
                        oam_data_d = bus_din;
                        state_d    = DMA_WRITE;
                    end
                end
            end
            DMA_WRITE: begin
                if (cpu_ce) begin
                    oam_wr_d = 1'b1;
                    index_d  = index_q + 8'd1;
                    state_d  = (index_q == LAST_INDEX) ? DMA_IDLE : DMA_READ;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they flip on the same edge as the FSM.
        cpu_halt_d = (state_d != DMA_IDLE);
        bus_rd_d   = (state_d == DMA_READ);
        bus_addr_d = {page_d, index_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DMA_IDLE;
            put_q      <= 1'b0;
            page_q     <= 8'h00;
            index_q    <= 8'h00;
            oam_data_q <= 8'h00;
            oam_wr_q   <= 1'b0;
            cpu_halt_q <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            put_q      <= put_d;
            page_q     <= page_d;
            index_q    <= index_d;
            oam_data_q <= oam_data_d;
            oam_wr_q   <= oam_wr_d;
            cpu_halt_q <= cpu_halt_d;
            bus_rd_q   <= bus_rd_d;
            bus_addr_q <= bus_addr_d;
        end
    end

    assign cpu_halt    = cpu_halt_q;
    assign bus_rd      = bus_rd_q;
    assign bus_addr    = bus_addr_q;
    assign oam_data_o  = oam_data_q;
    assign oam_data_wr = oam_wr_q;

endmodule
